// File: rtl/scan_index_sequencer.sv
// Scan index sequencer: registered index that walks 0..last (up or down, with
// wrap-around), holding each value for DWELL enabled clocks. Feeds the select
// input of binary_decoder directly.
//
// Ports:
//   clk       clock, all state updates on rising edge
//   rst       synchronous reset, active-high
//   en        run enable; 0 freezes index and dwell counter
//   dir       0 = count up, 1 = count down
//   last      highest index in scan range (range is 0..last)
//   load      synchronous load of load_val (clamped to last) into index
//   load_val  value for load
//   index     current scan index (registered)
//   tick      1-clk pulse: index changed by a step this cycle
//   wrap      1-clk pulse: the step wrapped (last->0 or 0->last)
module scan_index_sequencer #(
  parameter int unsigned N     = 3,
  parameter int unsigned DWELL = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         dir,
  input  logic [N-1:0] last,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] index,
  output logic         tick,
  output logic         wrap
);

  localparam int unsigned DW       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int unsigned DWELL_LM = (DWELL > 0) ? DWELL - 1 : 0;

  logic [DW-1:0] dwell;
  logic          dwell_done;
  logic [N-1:0]  step_index;
  logic          step_wrap;
  logic [N-1:0]  load_index;

  // Dwell expiry: the current index has been held for DWELL enabled clocks.
  assign dwell_done = (dwell == DW'(DWELL_LM));

  // Next index for a step; last/dir only matter here, so mid-dwell changes
  // are picked up at the next step. An index above last wraps either way.
  always_comb begin
    step_index = index;
    step_wrap  = 1'b0;
    if (!dir) begin
      if (index >= last) begin
        step_index = '0;
        step_wrap  = 1'b1;
      end else begin
        step_index = index + N'(1);
      end
    end else begin
      if ((index == '0) || (index > last)) begin
        step_index = last;
        step_wrap  = 1'b1;
      end else begin
        step_index = index - N'(1);
      end
    end
  end

  // Loaded value is clamped into the scan range.
  assign load_index = (load_val > last) ? last : load_val;

  // State and strobe registers; priority rst > load > en.
  always_ff @(posedge clk) begin
    if (rst) begin
      index <= '0;
      dwell <= '0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end else if (load) begin
      index <= load_index;
      dwell <= '0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end else if (en) begin
      if (dwell_done) begin
        index <= step_index;
        dwell <= '0;
        tick  <= 1'b1;
        wrap  <= step_wrap;
      end else begin
        dwell <= dwell + DW'(1);
        tick  <= 1'b0;
        wrap  <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_scan_index_sequencer.sv
// Directed self-checking bench for scan_index_sequencer. Instance u_dut uses
// N=3, DWELL=4; u_dut1 uses N=3, DWELL=1 and shares the same stimulus. The
// index is also checked through a one-hot decoder view.
module tb_scan_index_sequencer;

  logic       clk;
  logic       rst;
  logic       en;
  logic       dir;
  logic [2:0] last;
  logic       load;
  logic [2:0] load_val;
  logic [2:0] index;
  logic       tick;
  logic       wrap;
  logic [2:0] index1;
  logic       tick1;
  logic       wrap1;

  int checks;
  int failures;

  scan_index_sequencer #(.N(3), .DWELL(4)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .dir      (dir),
    .last     (last),
    .load     (load),
    .load_val (load_val),
    .index    (index),
    .tick     (tick),
    .wrap     (wrap)
  );

  scan_index_sequencer #(.N(3), .DWELL(1)) u_dut1 (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .dir      (dir),
    .last     (last),
    .load     (load),
    .load_val (load_val),
    .index    (index1),
    .tick     (tick1),
    .wrap     (wrap1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Full check of the DWELL=4 instance, including decoder one-hot view.
  task automatic expect_main(input string tag, input logic [2:0] ei, input logic et, input logic ew);
    logic [7:0] oh_got;
    logic [7:0] oh_exp;
    oh_got = 8'(1) << index;
    oh_exp = 8'(1) << ei;
    check({tag, "_index"}, 32'(index), 32'(ei));
    check({tag, "_onehot"}, 32'(oh_got), 32'(oh_exp));
    check({tag, "_tick"}, 32'(tick), 32'(et));
    check({tag, "_wrap"}, 32'(wrap), 32'(ew));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    en       = 1'b0;
    dir      = 1'b0;
    last     = 3'd5;
    load     = 1'b0;
    load_val = 3'd0;

    // Reset state
    cycles(1);
    expect_main("rst", 3'd0, 1'b0, 1'b0);
    check("rst1_index", 32'(index1), 32'd0);
    check("rst1_tick", 32'(tick1), 32'd0);

    // 1: up scan 0..5 with wrap, each value held 4 enabled clocks
    rst = 1'b0;
    en  = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      cycles(1);
      expect_main($sformatf("t1_k%0d", k), 3'((k / 4) % 6), 1'(k % 4 == 0),
                  1'((k % 4 == 0) && ((k / 4) % 6 == 0)));
    end

    // 2: enable gaps freeze dwell count
    do_reset();
    en = 1'b1;
    cycles(2);
    expect_main("t2_run2", 3'd0, 1'b0, 1'b0);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycles(1);
      expect_main($sformatf("t2_hold%0d", k), 3'd0, 1'b0, 1'b0);
    end
    en = 1'b1;
    cycles(1);
    expect_main("t2_re1", 3'd0, 1'b0, 1'b0);
    cycles(1);
    expect_main("t2_re2", 3'd1, 1'b1, 1'b0);

    // 3: down scan wraps 0 -> last, then plain decrement
    do_reset();
    dir  = 1'b1;
    last = 3'd5;
    cycles(3);
    expect_main("t3_pre", 3'd0, 1'b0, 1'b0);
    cycles(1);
    expect_main("t3_wrap", 3'd5, 1'b1, 1'b1);
    cycles(1);
    expect_main("t3_hold", 3'd5, 1'b0, 1'b0);
    cycles(3);
    expect_main("t3_dec", 3'd4, 1'b1, 1'b0);

    // 4: load clamps to last, overrides en, clears dwell
    dir      = 1'b0;
    cycles(2);
    load     = 1'b1;
    load_val = 3'd7;
    cycles(1);
    expect_main("t4_load", 3'd5, 1'b0, 1'b0);
    load = 1'b0;
    cycles(3);
    expect_main("t4_hold", 3'd5, 1'b0, 1'b0);
    cycles(1);
    expect_main("t4_wrap", 3'd0, 1'b1, 1'b1);
    load     = 1'b1;
    load_val = 3'd3;
    cycles(1);
    expect_main("t4_load_in", 3'd3, 1'b0, 1'b0);
    load = 1'b0;

    // 5: last change mid-dwell takes effect at step; reset mid-dwell
    do_reset();
    last = 3'd7;
    cycles(24);
    expect_main("t5_at6", 3'd6, 1'b1, 1'b0);
    cycles(2);
    last = 3'd2;
    cycles(1);
    expect_main("t5_mid", 3'd6, 1'b0, 1'b0);
    cycles(1);
    expect_main("t5_wrap", 3'd0, 1'b1, 1'b1);
    cycles(6);
    expect_main("t5_run", 3'd1, 1'b0, 1'b0);
    rst = 1'b1;
    cycles(1);
    expect_main("t5_rst", 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    cycles(3);
    expect_main("t5_after3", 3'd0, 1'b0, 1'b0);
    cycles(1);
    expect_main("t5_after4", 3'd1, 1'b1, 1'b0);

    // last=0: index stays 0, every step is a wrap, both directions
    do_reset();
    last = 3'd0;
    cycles(4);
    expect_main("l0_up", 3'd0, 1'b1, 1'b1);
    dir = 1'b1;
    cycles(4);
    expect_main("l0_dn", 3'd0, 1'b1, 1'b1);

    // 6: DWELL=1 steps every enabled clock
    dir  = 1'b0;
    last = 3'd7;
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      cycles(1);
      check($sformatf("t6_k%0d_index", k), 32'(index1), 32'(k % 8));
      check($sformatf("t6_k%0d_tick", k), 32'(tick1), 32'd1);
      check($sformatf("t6_k%0d_wrap", k), 32'(wrap1), 32'(k % 8 == 0));
    end
    en = 1'b0;
    cycles(1);
    check("t6_off_index", 32'(index1), 32'd1);
    check("t6_off_tick", 32'(tick1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
